// File: rtl/ca_code_nco_ctrl.sv
// ca_code_nco_ctrl
// Sequences the C/A code-clock NCO. A phase accumulator adds the active
// frequency word every cycle in RUN; each carry toggles code_clk. Each rising
// toggle is one chip: the chip counter advances and wraps every CHIPS chips
// with an epoch strobe. The code starts phase-aligned to a synchronised
// sync_in (1PPS) rising edge once armed. Frequency words arrive through a
// one-deep valid/ready slot. They are applied at once when not running, and
// only on chip boundaries while running.
//
// Ports:
//   clkin, rst            clock, asynchronous active-low reset
//   arm, stop             command pulses (stop wins over arm and sync)
//   sync_in               asynchronous 1PPS input
//   cfg_valid/cfg_word    frequency word offer; cfg_ready = slot empty
//   code_clk              generated code clock
//   chip_stb, chip_idx    chip strobe (rising code_clk) and chip index
//   epoch_stb             pulse when chip_idx becomes 0
//   running, state        RUN flag and FSM state (IDLE=0, ARMED=1, RUN=2)
module ca_code_nco_ctrl #(
    parameter int               ACC_W    = 64,
    parameter logic [ACC_W-1:0] DEF_WORD = 64'd754840767496194852,
    parameter int               CHIPS    = 1023,
    parameter int               IDX_W    = 10
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             arm,
    input  logic             stop,
    input  logic             sync_in,
    input  logic             cfg_valid,
    input  logic [ACC_W-1:0] cfg_word,
    output logic             cfg_ready,
    output logic             code_clk,
    output logic             chip_stb,
    output logic [IDX_W-1:0] chip_idx,
    output logic             epoch_stb,
    output logic             running,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           st_q, st_d;
    logic             s1, s2, s3;
    logic             sync_edge;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] active_word;
    logic [ACC_W-1:0] pend_word;
    logic [ACC_W:0]   sum;
    logic             advance, start, carry, rise, wrap;
    logic             xfer, copy;

    // Three-flop synchroniser; s1 may go metastable, s2/s3 give a clean edge.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sync_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_edge = s2 & ~s3;

    // FSM state register
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) st_q <= IDLE;
        else      st_q <= st_d;
    end

    // FSM next state: stop always wins
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (!stop && arm) st_d = ARMED;
            ARMED:   if (stop) st_d = IDLE;
                     else if (sync_edge) st_d = RUN;
            RUN:     if (stop) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    assign sum     = {1'b0, acc} + {1'b0, active_word};
    assign advance = (st_q == RUN) && !stop;
    assign start   = (st_q == ARMED) && !stop && sync_edge;
    assign carry   = advance && sum[ACC_W];
    assign rise    = carry && !code_clk;
    assign wrap    = (chip_idx == IDX_W'(CHIPS - 1));

    // NCO datapath. Outside an advancing RUN cycle everything is forced to its
    // start phase, except on the start edge, where code_clk rises as chip 0.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            code_clk  <= 1'b0;
            chip_idx  <= '0;
            chip_stb  <= 1'b0;
            epoch_stb <= 1'b0;
            running   <= 1'b0;
        end else begin
            chip_stb  <= start | rise;
            epoch_stb <= start | (rise & wrap);
            running   <= (st_d == RUN);
            if (advance) begin
                acc <= sum[ACC_W-1:0];
                if (carry) code_clk <= ~code_clk;
                if (rise)  chip_idx <= wrap ? '0 : chip_idx + IDX_W'(1);
            end else begin
                acc      <= '0;
                code_clk <= start;
                chip_idx <= '0;
            end
        end
    end

    // Word slot. While running, a pending word waits for a rising toggle so
    // that a chip never mixes two rates. A frozen NCO (word 0) never reaches
    // a boundary, so the word stays pending until the block leaves RUN.
    assign xfer = cfg_valid && cfg_ready;
    assign copy = !cfg_ready && ((st_q != RUN) || rise);

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            active_word <= DEF_WORD;
            pend_word   <= '0;
            cfg_ready   <= 1'b1;
        end else if (copy) begin
            active_word <= pend_word;
            cfg_ready   <= 1'b1;
        end else if (xfer) begin
            pend_word   <= cfg_word;
            cfg_ready   <= 1'b0;
        end
    end

    assign state = st_q;

endmodule

// File: doc/ca_code_nco_ctrl.md
Name: ca_code_nco_ctrl

Overview:
- Owns and sequences the C/A code-clock NCO: a 64-bit phase accumulator whose carry toggles the code clock.
- Arms on command, starts phase-aligned to an external sync (1PPS) edge, and stops on command.
- Accepts frequency-word updates through a valid/ready handshake and applies them only on chip boundaries.
- Counts chips 0..CHIPS-1 and flags code epochs for downstream code generator and correlator logic.

Parameters:
ACC_W, 64, accumulator width; the frequency word has this width.
DEF_WORD, 64'd754840767496194852, frequency word loaded at reset.
CHIPS, 1023, chips per code epoch.
IDX_W, 10, chip index width (ceil(log2(CHIPS))).

Ports:
clkin  in  1  system clock
rst  in  1  asynchronous, active-low reset
arm  in  1  single-cycle pulse; IDLE -> ARMED
stop  in  1  single-cycle pulse; any state -> IDLE
sync_in  in  1  asynchronous sync (1PPS); rising edge starts the code
cfg_valid  in  1  new frequency word offered
cfg_word  in  ACC_W  frequency word
cfg_ready  out  1  pending-word slot empty
code_clk  out  1  generated code clock
chip_stb  out  1  one-cycle pulse on each code_clk rising toggle
chip_idx  out  IDX_W  index of the current chip
epoch_stb  out  1  one-cycle pulse when chip_idx becomes 0
running  out  1  high in RUN
state  out  2  IDLE=0, ARMED=1, RUN=2

Behaviour:
- Reset (rst=0):
  - state=IDLE; acc=0; active_word=DEF_WORD; pending slot empty.
  - code_clk=0, chip_idx=0, chip_stb=0, epoch_stb=0, running=0, cfg_ready=1.
  - Sync flops cleared. Reset mid-run aborts immediately with no further toggles.
- Sync path:
  - sync_in passes through 3 flops s1->s2->s3; edge = s2 & ~s3.
  - A sync rise meeting setup is acted on at the 3rd rising clkin edge.
  - Edges seen outside ARMED are ignored.
- FSM:
  - IDLE: acc held at 0, code_clk=0. arm -> ARMED.
  - ARMED: acc held at 0. edge -> RUN. On the transition edge: acc<=0, code_clk<=1, chip_idx<=0, chip_stb=1 and epoch_stb=1 for that cycle.
  - RUN: each clock, sum = {1'b0,acc} + active_word (ACC_W+1 bits); acc <= sum[ACC_W-1:0].
  - On a carry (sum[ACC_W]=1), code_clk toggles on that same edge.
  - On a 0->1 toggle: chip_stb=1. chip_idx increments, wrapping CHIPS-1 -> 0; epoch_stb=1 on the wrap.
  - stop in ARMED or RUN -> IDLE next edge: code_clk<=0, chip_idx<=0, acc<=0, no strobes.
  - stop has priority over arm and over edge in the same cycle. arm outside IDLE is ignored.
- Word handshake:
  - Transfer occurs when cfg_valid & cfg_ready; the word goes into the pending slot and cfg_ready drops the next cycle.
  - In IDLE/ARMED a pending word is copied to active_word on the following edge.
  - In RUN it is copied on the edge that produces a 0->1 code_clk toggle (chip boundary). The first addition using it is in the next cycle.
  - cfg_ready returns to 1 the cycle after the copy. The copy and a new transfer never coincide.
  - The pending word survives stop. active_word persists across IDLE/RUN.
- Word boundary cases:
  - active_word=0 freezes code_clk at its current level; no strobes.
  - A word update with an empty FSM (IDLE) never produces a toggle.
- Outputs are all registered. chip_stb and epoch_stb are exactly one cycle wide.

Test Plan:
- Reset then idle 100 cycles, with sync_in toggling -> code_clk=0, state=0, cfg_ready=1, no strobes.
- Load word 2^63 in IDLE, arm, raise sync_in:
  - RUN entered at the 3rd clkin edge after the sync rise, with code_clk=1 and chip_stb=epoch_stb=1 on that edge.
  - code_clk then toggles every 2 cycles (period 4).
  - chip_idx reaches 1022; epoch_stb recurs exactly every 4092 cycles.
- In RUN with word 2^63, offer word 2^62 mid-chip -> cfg_ready falls.
  - The new word takes effect only after the next rising toggle; code_clk period becomes 8 cycles from that chip on.
  - cfg_ready rises one cycle after the copy.
- stop and a sync edge in the same cycle while ARMED -> state=IDLE, no strobes. stop in RUN -> code_clk=0 and chip_idx=0 on the next edge.
- Assert rst mid-run at chip_idx=500 -> all outputs reach reset values immediately. After release, the bench re-arms and syncs and chip_idx restarts at 0.
- Word 0 in RUN -> code_clk holds its level and no chip_stb occurs. Then load 2^63 -> the update stays pending (no boundary) until stop returns the block to IDLE, where it is applied.
